etapa_mem_vectorial: RTL and testbench

Memory stage of the vector pipeline. It consumes the EXE/MEM register outputs and performs scalar (1-byte) or vector (4-byte) loads and stores over a byte-wide request/acknowledge data-memory port. It stalls the upstream pipeline while the access runs, then registers results and write-back controls toward the MEM/WB register. Non-memory instructions pass through with one cycle of latency.

---
 rtl/etapa_mem_vectorial.sv | 191 +++++++++++++++++++
 tb/tb_etapa_mem_vectorial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_mem_vectorial.sv
// Vector pipeline memory stage: scalar/vector loads and stores over a
// byte-wide req/ack data port, with per-beat timeout and upstream stall.
module etapa_mem_vectorial #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sum_mem_in,
   input  logic              sel_mem_in,
   input  logic              sel_data_in,
   input  logic              mem_wr_in,
   input  logic              sel_wb_in,
   input  logic              reg_wrv_in,
   input  logic              reg_wrs_in,
   input  logic [31:0]       DATA1_in,
   input  logic [31:0]       ALU_in,
   input  logic [2:0]        dir_dest_in,
   input  logic [7:0]        inmediato_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              valid_out,
   output logic              sel_wb_out,
   output logic              reg_wrv_out,
   output logic              reg_wrs_out,
   output logic [2:0]        dir_dest_out,
   output logic [31:0]       ALU_out,
   output logic [31:0]       mem_data_out,
   output logic              mem_err_out
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t state;
   state_t state_n;

   logic              l_vec;
   logic              l_we;
   logic              l_sel_wb;
   logic              l_wrv;
   logic              l_wrs;
   logic [2:0]        l_dest;
   logic [31:0]       l_alu;
   logic [31:0]       l_data1;
   logic [ADDR_W-1:0] base;
   logic [1:0]        beat;
   logic [7:0]        wcnt;
   logic [31:0]       lbuf;

   logic              last;
   logic              done;
   logic              tout;
   logic [ADDR_W-1:0] imm_a;
   logic [ADDR_W-1:0] base_n;
   logic [31:0]       lbuf_n;

   // beat address, write strobe and store byte for the current beat
   assign mem_addr  = base + ADDR_W'(beat);
   assign mem_we    = mem_req & l_we;
   assign mem_wdata = l_data1[{beat, 3'b000} +: 8];

   // next state, handshake outputs, and access-completion decode
   always_comb begin
      state_n = state;
      mem_req = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      tout    = 1'b0;
      last    = l_vec ? (beat == 2'd3) : 1'b1;
      imm_a   = ADDR_W'(inmediato_in);
      base_n  = ALU_in[ADDR_W-1:0] + (sum_mem_in ? imm_a : '0);
      lbuf_n  = lbuf;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               stall = sel_mem_in;
               if (sel_mem_in)
                  state_n = ACCESS;
            end
            ACCESS: begin
               mem_req = 1'b1;
               done    = mem_ack && last;
               tout    = !mem_ack && (wcnt == WAIT_LAST);
               stall   = !(done || tout);
               if (mem_ack && !l_we)
                  lbuf_n[{beat, 3'b000} +: 8] = mem_rdata;
               if (done || tout)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // instruction latch, beat/wait counters and load buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         l_vec    <= 1'b0;
         l_we     <= 1'b0;
         l_sel_wb <= 1'b0;
         l_wrv    <= 1'b0;
         l_wrs    <= 1'b0;
         l_dest   <= '0;
         l_alu    <= '0;
         l_data1  <= '0;
         base     <= '0;
         beat     <= '0;
         wcnt     <= '0;
         lbuf     <= '0;
      end else if (state == IDLE) begin
         if (sel_mem_in) begin
            l_vec    <= sel_data_in;
            l_we     <= mem_wr_in;
            l_sel_wb <= sel_wb_in;
            l_wrv    <= reg_wrv_in;
            l_wrs    <= reg_wrs_in;
            l_dest   <= dir_dest_in;
            l_alu    <= ALU_in;
            l_data1  <= DATA1_in;
            base     <= base_n;
            beat     <= '0;
            wcnt     <= '0;
            lbuf     <= '0;
         end
      end else begin
         lbuf <= lbuf_n;
         if (mem_ack) begin
            wcnt <= '0;
            beat <= beat + 2'd1;
         end else begin
            wcnt <= wcnt + 8'd1;
         end
      end
   end

   // MEM/WB result registers; valid and write enables pulse once
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out    <= 1'b0;
         sel_wb_out   <= 1'b0;
         reg_wrv_out  <= 1'b0;
         reg_wrs_out  <= 1'b0;
         dir_dest_out <= '0;
         ALU_out      <= '0;
         mem_data_out <= '0;
         mem_err_out  <= 1'b0;
      end else begin
         valid_out   <= 1'b0;
         reg_wrv_out <= 1'b0;
         reg_wrs_out <= 1'b0;
         mem_err_out <= 1'b0;
         if (state == IDLE && !sel_mem_in) begin
            valid_out    <= 1'b1;
            sel_wb_out   <= sel_wb_in;
            reg_wrv_out  <= reg_wrv_in;
            reg_wrs_out  <= reg_wrs_in;
            dir_dest_out <= dir_dest_in;
            ALU_out      <= ALU_in;
            mem_data_out <= '0;
         end else if (done || tout) begin
            valid_out    <= 1'b1;
            sel_wb_out   <= l_sel_wb;
            reg_wrv_out  <= l_wrv & ~tout;
            reg_wrs_out  <= l_wrs & ~tout;
            dir_dest_out <= l_dest;
            ALU_out      <= l_alu;
            mem_data_out <= l_we ? 32'h0 : lbuf_n;
            mem_err_out  <= tout;
         end
      end
   end

endmodule

// File: tb/tb_etapa_mem_vectorial.sv
// Bench for etapa_mem_vectorial: vector table plus reset sequences,
// with a byte memory responder having programmable per-beat wait.
module tb_etapa_mem_vectorial;

   logic        clk = 1'b0;
   logic        reset;
   logic        sum_mem_in, sel_mem_in, sel_data_in, mem_wr_in;
   logic        sel_wb_in, reg_wrv_in, reg_wrs_in;
   logic [31:0] DATA1_in, ALU_in;
   logic [2:0]  dir_dest_in;
   logic [7:0]  inmediato_in;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr, mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        stall, valid_out, sel_wb_out, reg_wrv_out, reg_wrs_out;
   logic [2:0]  dir_dest_out;
   logic [31:0] ALU_out, mem_data_out;
   logic        mem_err_out;

   etapa_mem_vectorial #(.ADDR_W(8), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .sum_mem_in(sum_mem_in), .sel_mem_in(sel_mem_in),
      .sel_data_in(sel_data_in), .mem_wr_in(mem_wr_in),
      .sel_wb_in(sel_wb_in), .reg_wrv_in(reg_wrv_in),
      .reg_wrs_in(reg_wrs_in), .DATA1_in(DATA1_in),
      .ALU_in(ALU_in), .dir_dest_in(dir_dest_in),
      .inmediato_in(inmediato_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .stall(stall), .valid_out(valid_out),
      .sel_wb_out(sel_wb_out), .reg_wrv_out(reg_wrv_out),
      .reg_wrs_out(reg_wrs_out), .dir_dest_out(dir_dest_out),
      .ALU_out(ALU_out), .mem_data_out(mem_data_out),
      .mem_err_out(mem_err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sum_mem, sel_mem, sel_data, mem_wr, sel_wb, wrv, wrs;
      logic [31:0] data1, alu;
      logic [2:0]  dest;
      logic [7:0]  imm;
      int          rwait;
      logic        rnever;
      logic [31:0] e_data;
      logic        e_err, e_wrv, e_wrs;
      int          e_acc, e_stall, e_nb;
      logic [7:0]  e_a0;
      logic        e_we;
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [256];
   int         rsp_wait = 0;
   logic       rsp_never = 1'b0;
   int         rsp_cnt = 0;
   logic [7:0] log_a [16];
   logic       log_we [16];
   logic [7:0] log_wd [16];
   int         nlog = 0;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
   end

   // responder: acks after rsp_wait idle cycles per beat
   always @(posedge clk) begin
      #2;
      if (mem_req && !rsp_never) begin
         if (rsp_cnt == rsp_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            rsp_cnt   = 0;
         end else begin
            mem_ack = 1'b0;
            rsp_cnt = rsp_cnt + 1;
         end
      end else begin
         mem_ack = 1'b0;
         rsp_cnt = 0;
      end
   end

   // completed beats: log them and commit stores
   always @(negedge clk) begin
      if (mem_req && mem_ack) begin
         if (nlog < 16) begin
            log_a[nlog]  = mem_addr;
            log_we[nlog] = mem_we;
            log_wd[nlog] = mem_wdata;
         end
         nlog = nlog + 1;
         if (mem_we)
            mem[mem_addr] = mem_wdata;
      end
   end

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      sum_mem_in   = v.sum_mem;
      sel_mem_in   = v.sel_mem;
      sel_data_in  = v.sel_data;
      mem_wr_in    = v.mem_wr;
      sel_wb_in    = v.sel_wb;
      reg_wrv_in   = v.wrv;
      reg_wrs_in   = v.wrs;
      DATA1_in     = v.data1;
      ALU_in       = v.alu;
      dir_dest_in  = v.dest;
      inmediato_in = v.imm;
   endtask

   vec_t tv [9];
   vec_t nop;

   initial begin
      int cyc, acc, stl;
      logic        ok_a, ok_we;
      logic [31:0] wd, msk;
      logic [7:0]  ea;
      string       p;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB;
      mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
      mem[8'h25] = 8'h7E;

      //        sm sel vd wr wb wv ws data1  alu  dest imm  wt nv
      //        e_data e_err e_wrv e_wrs acc stl nb a0 we
      tv[0] = '{0,0,0,0,1,1,0, 32'h0, 32'h12345678, 3'd5, 8'h00, 0,0,
                32'h0, 0,1,0, 0,0,0, 8'h00, 0};
      tv[1] = '{0,1,1,0,0,1,0, 32'hFFFFFFFF, 32'h10, 3'd3, 8'h77, 0,0,
                32'hDDCCBBAA, 0,1,0, 4,4,4, 8'h10, 0};
      tv[2] = '{1,1,1,1,1,0,0, 32'h44332211, 32'hF0, 3'd1, 8'h0E, 2,0,
                32'h0, 0,0,0, 12,12,4, 8'hFE, 1};
      tv[3] = '{1,1,1,0,0,1,0, 32'h0, 32'hFD, 3'd7, 8'h01, 1,0,
                32'h44332211, 0,1,0, 8,8,4, 8'hFE, 0};
      tv[4] = '{0,1,0,0,1,0,1, 32'h0, 32'h125, 3'd2, 8'h40, 0,0,
                32'h7E, 0,0,1, 1,1,1, 8'h25, 0};
      tv[5] = '{0,1,0,0,0,0,1, 32'h0, 32'h30, 3'd4, 8'h00, 0,1,
                32'h0, 1,0,0, 16,16,0, 8'h30, 0};
      tv[6] = '{0,1,0,1,0,0,0, 32'hA5A5A5C3, 32'h40, 3'd0, 8'h00, 0,0,
                32'h0, 0,0,0, 1,1,1, 8'h40, 1};
      tv[7] = '{1,1,0,0,1,0,1, 32'h0, 32'h3F, 3'd6, 8'h01, 3,0,
                32'hC3, 0,0,1, 4,4,1, 8'h40, 0};
      tv[8] = '{0,1,1,0,1,1,0, 32'h0, 32'h80, 3'd2, 8'h00, 0,1,
                32'h0, 1,0,0, 16,16,0, 8'h80, 0};
      nop   = '{0,0,0,0,0,0,0, 32'h0, 32'h0, 3'd0, 8'h00, 0,0,
                32'h0, 0,0,0, 0,0,0, 8'h00, 0};

      // reset held two cycles with a memory op pending
      reset = 1'b1;
      drive(tv[1]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst stall", {31'b0, stall}, 32'h0);
      chk("rst mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst valid", {31'b0, valid_out}, 32'h0);
      chk("rst alu", ALU_out, 32'h0);
      chk("rst data", mem_data_out, 32'h0);
      chk("rst flags", {27'b0, sel_wb_out, reg_wrv_out, reg_wrs_out,
                        mem_err_out, 1'b0} | {29'b0, dir_dest_out}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(nop);

      for (int i = 0; i < 9; i++) begin
         p = $sformatf("v%0d", i);
         rsp_wait  = tv[i].rwait;
         rsp_never = tv[i].rnever;
         nlog = 0;
         drive(tv[i]);
         cyc = 0; acc = 0; stl = 0;
         do begin
            @(negedge clk);
            if (stall) stl++;
            if (mem_req) acc++;
            @(posedge clk);
            #1;
            cyc++;
         end while (!valid_out && cyc < 60);
         chk({p, " valid"}, {31'b0, valid_out}, 32'h1);
         chk({p, " cycles"}, cyc, tv[i].e_acc + 1);
         chk({p, " acc"}, acc, tv[i].e_acc);
         chk({p, " stall"}, stl, tv[i].e_stall);
         chk({p, " alu"}, ALU_out, tv[i].alu);
         chk({p, " dest"}, {29'b0, dir_dest_out}, {29'b0, tv[i].dest});
         chk({p, " selwb"}, {31'b0, sel_wb_out}, {31'b0, tv[i].sel_wb});
         chk({p, " wrv"}, {31'b0, reg_wrv_out}, {31'b0, tv[i].e_wrv});
         chk({p, " wrs"}, {31'b0, reg_wrs_out}, {31'b0, tv[i].e_wrs});
         chk({p, " err"}, {31'b0, mem_err_out}, {31'b0, tv[i].e_err});
         chk({p, " data"}, mem_data_out, tv[i].e_data);
         chk({p, " beats"}, nlog, tv[i].e_nb);
         ok_a = 1'b1; ok_we = 1'b1; wd = 32'h0;
         for (int b = 0; b < nlog && b < 4; b++) begin
            ea = tv[i].e_a0 + 8'(b);
            if (log_a[b] !== ea) ok_a = 1'b0;
            if (log_we[b] !== tv[i].e_we) ok_we = 1'b0;
            wd[8*b +: 8] = log_wd[b];
         end
         chk({p, " addrs"}, {31'b0, ok_a}, 32'h1);
         chk({p, " we"}, {31'b0, ok_we}, 32'h1);
         if (tv[i].e_we) begin
            msk = (tv[i].e_nb == 4) ? 32'hFFFFFFFF : 32'h000000FF;
            chk({p, " wdata"}, wd & msk, tv[i].data1 & msk);
         end
      end

      // write-enable pulses only once per instruction
      drive(nop);
      @(posedge clk);
      #1;
      chk("pulse wrs", {31'b0, reg_wrs_out}, 32'h0);

      // reset while a vector load is on beat 2
      rsp_wait = 0; rsp_never = 1'b0;
      drive(tv[1]);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid rst stall", {31'b0, stall}, 32'h0);
      chk("mid rst req", {31'b0, mem_req}, 32'h0);
      @(posedge clk);
      #1;
      chk("mid rst valid", {31'b0, valid_out}, 32'h0);
      chk("mid rst data", mem_data_out, 32'h0);
      reset = 1'b0;
      drive(nop);
      ALU_in = 32'hCAFE0001; dir_dest_in = 3'd6; reg_wrs_in = 1'b1;
      @(negedge clk);
      chk("post rst req", {31'b0, mem_req}, 32'h0);
      @(posedge clk);
      #1;
      chk("post rst valid", {31'b0, valid_out}, 32'h1);
      chk("post rst alu", ALU_out, 32'hCAFE0001);
      chk("post rst dest", {29'b0, dir_dest_out}, 32'h6);
      chk("post rst wrs", {31'b0, reg_wrs_out}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
